// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin mux arbiter and its picker.
package mux_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Index/counter width with a floor of one bit so degenerate sizes still elaborate.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotate-search: first set request at or after i_ptr, wrapping at N.
module rr_priority_pick
    import mux_rr_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [SW-1:0] i_ptr,
    output logic [N-1:0]  o_pick,
    output logic [SW-1:0] o_idx,
    output logic          o_any
);

    // Walk the requesters starting at the pointer; the first hit wins.
    always_comb begin
        int j;
        j      = 0;
        o_pick = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[j]) begin
                o_any     = 1'b1;
                o_pick[j] = 1'b1;
                o_idx     = SW'(j);
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter sharing one N:1 data mux; grant held until LAST or MAX_BEATS.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                      C,
    input  logic                      R,
    input  logic [N-1:0]              REQ,
    input  logic [N-1:0]              LAST,
    input  logic [N*W-1:0]            D,
    output logic [N-1:0]              RDY,
    output logic [N-1:0]              GNT,
    output logic [idx_width(N)-1:0]   SEL,
    output logic [W-1:0]              Y,
    output logic                      Y_VALID,
    output logic                      Y_LAST,
    input  logic                      Y_READY
);

    localparam int SW = idx_width(N);
    localparam int CW = idx_width(MAX_BEATS + 1);

    arb_state_t    r_state;
    arb_state_t    w_state_next;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  w_gnt_next;
    logic [SW-1:0] r_sel;
    logic [SW-1:0] w_sel_next;
    logic [SW-1:0] r_ptr;
    logic [SW-1:0] w_ptr_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    logic [N-1:0]  w_pick;
    logic [SW-1:0] w_pick_idx;
    logic          w_pick_any;

    logic          w_busy;
    logic          w_req_sel;
    logic          w_last_sel;
    logic          w_accept;
    logic [CW-1:0] w_cnt_inc;
    logic          w_cap_hit;
    logic [SW-1:0] w_sel_inc;

    rr_priority_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .i_req  (REQ),
        .i_ptr  (r_ptr),
        .o_pick (w_pick),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    assign w_busy     = (r_state == ST_BUSY);
    assign w_req_sel  = REQ[r_sel];
    assign w_last_sel = LAST[r_sel];
    assign w_accept   = w_busy && w_req_sel && Y_READY && !R;
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_cap_hit  = (MAX_BEATS != 0) && (w_cnt_inc == CW'(MAX_BEATS));
    assign w_sel_inc  = (r_sel == SW'(N - 1)) ? '0 : r_sel + 1'b1;

    assign GNT = r_gnt;
    assign SEL = r_sel;
    assign Y   = D[r_sel*W +: W];

    // Handshake gating: only the granted lane sees ready, and nothing moves while reset is held.
    always_comb begin
        RDY     = '0;
        Y_VALID = 1'b0;
        Y_LAST  = 1'b0;
        if (w_busy && !R) begin
            Y_VALID    = w_req_sel;
            Y_LAST     = w_last_sel;
            RDY[r_sel] = Y_READY;
        end
    end

    // Next-state: IDLE always spends one cycle arbitrating, so grants are never back-to-back.
    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_sel_next   = r_sel;
        w_ptr_next   = r_ptr;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_next = ST_BUSY;
                    w_gnt_next   = w_pick;
                    w_sel_next   = w_pick_idx;
                    w_cnt_next   = '0;
                end
            end
            ST_BUSY: begin
                if (w_accept) begin
                    if (w_last_sel || w_cap_hit) begin
                        w_state_next = ST_IDLE;
                        w_gnt_next   = '0;
                        w_ptr_next   = w_sel_inc;
                        w_cnt_next   = '0;
                    end else if (MAX_BEATS != 0) begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (R) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_sel   <= w_sel_next;
            r_ptr   <= w_ptr_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Grant sanity: one-hot or zero, and the select must point at the granted lane.
    always_ff @(posedge C) begin
        if (!R) begin
            assert ($onehot0(r_gnt));
            if (r_gnt != '0) begin
                assert (r_gnt[r_sel]);
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized and directed bench for mux_rr_arbiter against an integer-level round-robin model.
module tb_mux_rr_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  last;
    logic [N*W-1:0] d;
    logic          yReady;
    logic [N-1:0]  rdy;
    logic [N-1:0]  gnt;
    logic [1:0]    sel;
    logic [W-1:0]  y;
    logic          yValid;
    logic          yLast;

    int checks = 0;
    int errors = 0;

    bit mBusy;
    int mSel;
    int mPtr;
    int mCnt;

    mux_rr_arbiter #(
        .N         (N),
        .W         (W),
        .MAX_BEATS (MAXB)
    ) dut (
        .C       (clk),
        .R       (rst),
        .REQ     (req),
        .LAST    (last),
        .D       (d),
        .RDY     (rdy),
        .GNT     (gnt),
        .SEL     (sel),
        .Y       (y),
        .Y_VALID (yValid),
        .Y_LAST  (yLast),
        .Y_READY (yReady)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mBusy = 1'b0;
        mSel  = 0;
        mPtr  = 0;
        mCnt  = 0;
    endtask

    // Reference: grant goes to the first requester at or after the pointer; release on LAST or cap.
    task automatic modelUpdate();
        if (rst) begin
            modelReset();
        end else if (!mBusy) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (mPtr + k) % N;
                if (!mBusy && req[idx]) begin
                    mBusy = 1'b1;
                    mSel  = idx;
                    mCnt  = 0;
                end
            end
        end else if (req[mSel] && yReady) begin
            mCnt++;
            if (last[mSel] || mCnt == MAXB) begin
                mBusy = 1'b0;
                mPtr  = (mSel + 1) % N;
                mCnt  = 0;
            end
        end
    endtask

    task automatic checkOutput();
        logic [31:0] expGnt;
        logic [31:0] expRdy;
        logic        active;
        active = mBusy && !rst;
        expGnt = mBusy ? (32'd1 << mSel) : 32'd0;
        expRdy = (active && yReady) ? (32'd1 << mSel) : 32'd0;
        checkValue("gnt",    32'(gnt),    expGnt);
        checkValue("sel",    32'(sel),    32'(mSel));
        checkValue("y",      32'(y),      32'(d[mSel*W +: W]));
        checkValue("yValid", 32'(yValid), 32'(active && req[mSel]));
        checkValue("rdy",    32'(rdy),    expRdy);
        checkValue("yLast",  32'(yLast),  32'(active && last[mSel]));
    endtask

    // One cycle: drive inputs, compare mid-cycle, then advance the model across the edge.
    task automatic applyStimulus(input logic r, input logic [N-1:0] rq,
                                 input logic [N-1:0] ls, input logic rd);
        rst    = r;
        req    = rq;
        last   = ls;
        yReady = rd;
        d      = $urandom;
        #4;
        checkOutput();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    logic [N-1:0] rrOrder [10] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                   4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};

    initial begin
        rst    = 1'b1;
        req    = '0;
        last   = '0;
        d      = '0;
        yReady = 1'b0;
        repeat (2) @(posedge clk);
        modelReset();
        #1;

        $display("[TB] reset state");
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        checkValue("rst_gnt", 32'(gnt), 32'd0);
        checkValue("rst_sel", 32'(sel), 32'd0);

        $display("[TB] single requester, three-beat burst");
        applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b1);
        checkValue("s1_grant", 32'(gnt), 32'h1);
        applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b1);
        checkValue("s1_release", 32'(gnt), 32'h0);

        $display("[TB] all requesters, single-beat bursts");
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1);
            checkValue("s2_order", 32'(gnt), 32'(rrOrder[i]));
        end

        $display("[TB] downstream stall mid-burst");
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b1);
        checkValue("s3_grant", 32'(gnt), 32'h2);
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b0);
            checkValue("s3_hold_gnt", 32'(gnt), 32'h2);
            checkValue("s3_hold_rdy", 32'(rdy), 32'h0);
        end
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b1);
        checkValue("s3_beat3_gnt", 32'(gnt), 32'h2);
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b1);
        checkValue("s3_cap_release", 32'(gnt), 32'h0);

        $display("[TB] beat cap forces re-arbitration");
        applyStimulus(1'b0, 4'b0101, 4'b0000, 1'b1);
        checkValue("s4_grant2", 32'(gnt), 32'h4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'b0101, 4'b0000, 1'b1);
            checkValue("s4_held", 32'(gnt), 32'h4);
        end
        applyStimulus(1'b0, 4'b0101, 4'b0000, 1'b1);
        checkValue("s4_release", 32'(gnt), 32'h0);
        applyStimulus(1'b0, 4'b0101, 4'b0000, 1'b1);
        checkValue("s4_next_grant0", 32'(gnt), 32'h1);
        applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b1);

        $display("[TB] reset mid-burst");
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0010, 4'b0000, 1'b1);
        checkValue("s5_gnt_dropped", 32'(gnt), 32'h0);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1);
        checkValue("s5_regrant0", 32'(gnt), 32'h1);
        applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b1);

        $display("[TB] granted requester pauses");
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b1);
        checkValue("s6_grant", 32'(gnt), 32'h2);
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 4'b1101, 4'b0000, 1'b1);
            checkValue("s6_gnt_held", 32'(gnt), 32'h2);
        end
        applyStimulus(1'b0, 4'b0010, 4'b0010, 1'b1);
        checkValue("s6_release", 32'(gnt), 32'h0);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          N'($urandom),
                          N'($urandom & $urandom),
                          ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
